// File: rtl/bcp_clause_scheduler.sv
// bcp_clause_scheduler
//   Collects clause-pending flags from literal evaluation and issues one pending
//   clause index per cycle, lowest index first, to the clause-evaluation stage.
//   It also reports the end of each propagation round.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   flag_valid  flag_vec is valid this cycle
//   flag_vec    clauses to mark pending (bit i = clause i)
//   flush       drop all pending work and any clause waiting in the output slot
//   cl_valid    cl_idx holds a clause to evaluate (registered)
//   cl_idx      issued clause index (registered)
//   cl_ready    downstream accepts cl_idx this cycle
//   pending     current pending vector
//   busy        FSM is in BUSY
//   round_done  one-cycle pulse when a round completes (registered)
module bcp_clause_scheduler #(
    parameter int unsigned CLAUSE_NUM     = 8,
    parameter int unsigned CLAUSE_NUM_LOG = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flag_valid,
    input  logic [CLAUSE_NUM-1:0]     flag_vec,
    input  logic                      flush,
    output logic                      cl_valid,
    output logic [CLAUSE_NUM_LOG-1:0] cl_idx,
    input  logic                      cl_ready,
    output logic [CLAUSE_NUM-1:0]     pending,
    output logic                      busy,
    output logic                      round_done
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [CLAUSE_NUM-1:0]     pending_q, pending_d;
    logic                      valid_q, valid_d;
    logic [CLAUSE_NUM_LOG-1:0] idx_q, idx_d;
    logic [0:0]                state_q, state_d;
    logic                      round_done_q, round_done_d;

    logic                      enc_any;
    logic [CLAUSE_NUM_LOG-1:0] enc_idx;
    logic                      slot_load;

    // Lowest set bit wins, matching the downstream priority encoder.
    always_comb begin
        enc_any = |pending_q;
        enc_idx = '0;
        for (int i = CLAUSE_NUM - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc_idx = CLAUSE_NUM_LOG'(i);
            end
        end
    end

    // The slot refills when empty or when its current entry is being popped.
    // cl_ready only reaches registers, so there is no combinational path to the outputs.
    assign slot_load = !valid_q || cl_ready;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (slot_load) begin
            valid_d = enc_any;
            if (enc_any) begin
                idx_d = enc_idx;
            end
        end
    end

    // Clear the issued bit first, then OR in new flags, so a clause that is
    // re-flagged in the cycle it is issued stays pending and is issued again.
    always_comb begin
        pending_d = pending_q;
        if (slot_load && enc_any) begin
            pending_d[enc_idx] = 1'b0;
        end
        if (flag_valid) begin
            pending_d = pending_d | flag_vec;
        end
        if (flush) begin
            pending_d = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_done_d = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enc_any || valid_q) begin
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    // A flag arriving this cycle means the round is not over yet.
                    if (!enc_any && !valid_q && !flag_valid) begin
                        state_d      = StIdle;
                        round_done_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            valid_q      <= 1'b0;
            idx_q        <= '0;
            state_q      <= StIdle;
            round_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            round_done_q <= round_done_d;
        end
    end

    assign cl_valid   = valid_q;
    assign cl_idx     = idx_q;
    assign pending    = pending_q;
    assign busy       = (state_q == StBusy);
    assign round_done = round_done_q;

endmodule

// File: tb/tb_bcp_clause_scheduler.sv
module tb_bcp_clause_scheduler;

    logic       clk;
    logic       rst;
    logic       flag_valid;
    logic [7:0] flag_vec;
    logic       flush;
    logic       cl_valid;
    logic [2:0] cl_idx;
    logic       cl_ready;
    logic [7:0] pending;
    logic       busy;
    logic       round_done;

    int errors = 0;
    int checks = 0;

    bcp_clause_scheduler #(
        .CLAUSE_NUM     (8),
        .CLAUSE_NUM_LOG (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flag_valid (flag_valid),
        .flag_vec   (flag_vec),
        .flush      (flush),
        .cl_valid   (cl_valid),
        .cl_idx     (cl_idx),
        .cl_ready   (cl_ready),
        .pending    (pending),
        .busy       (busy),
        .round_done (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flag_valid = 1'b0; flag_vec = 8'h00; flush = 1'b0; cl_ready = 1'b0;
        #12;
        checks++;
        if (pending !== 8'h00 || cl_valid !== 1'b0 || cl_idx !== 3'd0 || busy !== 1'b0 ||
            round_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: pending=%h valid=%b idx=%0d busy=%b rd=%b, required 00 0 0 0 0",
                     pending, cl_valid, cl_idx, busy, round_done);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_issue();
        logic [2:0] exp_idx [3];
        logic [7:0] exp_pend [3];
        exp_idx  = '{3'd2, 3'd5, 3'd7};
        exp_pend = '{8'hA0, 8'h80, 8'h00};
        cl_ready = 1'b1; flag_valid = 1'b1; flag_vec = 8'b1010_0100;
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        checks++;
        if (pending !== 8'hA4 || cl_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_t1: pending=%h valid=%b busy=%b, required a4 0 0",
                     pending, cl_valid, busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (cl_valid !== 1'b1 || cl_idx !== exp_idx[k] || pending !== exp_pend[k] ||
                busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_issue%0d: valid=%b idx=%0d pending=%h busy=%b, required 1 %0d %h 1",
                         k, cl_valid, cl_idx, pending, busy, exp_idx[k], exp_pend[k]);
            end
        end
        tick();
        checks++;
        if (cl_valid !== 1'b0 || round_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: valid=%b rd=%b busy=%b, required 0 0 1",
                     cl_valid, round_done, busy);
        end
        tick();
        checks++;
        if (round_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_round_done: rd=%b busy=%b, required 1 0", round_done, busy);
        end
        tick();
        checks++;
        if (round_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: rd=%b, required 0", round_done);
        end
    endtask

    task automatic test_backpressure();
        cl_ready = 1'b0; flag_valid = 1'b1; flag_vec = 8'b0001_1000;
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (cl_valid !== 1'b1 || cl_idx !== 3'd3 || pending !== 8'h10) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b idx=%0d pending=%h, required 1 3 10",
                         k, cl_valid, cl_idx, pending);
            end
        end
        cl_ready = 1'b1;
        tick();
        checks++;
        if (cl_valid !== 1'b1 || cl_idx !== 3'd4 || pending !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: valid=%b idx=%0d pending=%h, required 1 4 00",
                     cl_valid, cl_idx, pending);
        end
        tick();
        tick();
        checks++;
        if (round_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_round_done: rd=%b busy=%b, required 1 0", round_done, busy);
        end
        tick();
    endtask

    task automatic test_reflag_same_cycle();
        cl_ready = 1'b1; flag_valid = 1'b1; flag_vec = 8'h08;
        tick();
        // Slot loads 3 on the next edge while bit 3 is flagged again.
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        checks++;
        if (cl_valid !== 1'b1 || cl_idx !== 3'd3 || pending !== 8'h08) begin
            errors++;
            $display("FAIL reflag_first: valid=%b idx=%0d pending=%h, required 1 3 08",
                     cl_valid, cl_idx, pending);
        end
        tick();
        checks++;
        if (cl_valid !== 1'b1 || cl_idx !== 3'd3 || pending !== 8'h00) begin
            errors++;
            $display("FAIL reflag_second: valid=%b idx=%0d pending=%h, required 1 3 00",
                     cl_valid, cl_idx, pending);
        end
        tick();
        tick();
        checks++;
        if (round_done !== 1'b1) begin
            errors++;
            $display("FAIL reflag_round_done: rd=%b, required 1", round_done);
        end
        tick();
    endtask

    task automatic test_flush();
        cl_ready = 1'b0; flag_valid = 1'b1; flag_vec = 8'hF1;
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        tick();
        checks++;
        if (pending !== 8'hF0 || cl_valid !== 1'b1 || cl_idx !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: pending=%h valid=%b idx=%0d busy=%b, required f0 1 0 1",
                     pending, cl_valid, cl_idx, busy);
        end
        flush = 1'b1; flag_valid = 1'b1; flag_vec = 8'h01;
        tick();
        flush = 1'b0; flag_valid = 1'b0; flag_vec = 8'h00;
        checks++;
        if (pending !== 8'h00 || cl_valid !== 1'b0 || busy !== 1'b0 || round_done !== 1'b0) begin
            errors++;
            $display("FAIL flush: pending=%h valid=%b busy=%b rd=%b, required 00 0 0 0",
                     pending, cl_valid, busy, round_done);
        end
        tick();
        checks++;
        if (pending !== 8'h00 || cl_valid !== 1'b0 || busy !== 1'b0 || round_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: pending=%h valid=%b busy=%b rd=%b, required 00 0 0 0",
                     pending, cl_valid, busy, round_done);
        end
    endtask

    task automatic test_all_ones_backpressure();
        logic [3:0] exp_idx;
        int         hs;
        bit         done_seen;
        bit         r;
        exp_idx = 4'd0; hs = 0; done_seen = 1'b0;
        cl_ready = 1'b0; flag_valid = 1'b1; flag_vec = 8'hFF;
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (round_done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1));
                cl_ready = r;
                if (cl_valid === 1'b1 && r) begin
                    checks++;
                    if ({1'b0, cl_idx} !== exp_idx) begin
                        errors++;
                        $display("FAIL ones_order: idx=%0d, required %0d", cl_idx, exp_idx);
                    end
                    exp_idx++;
                    hs++;
                end
                tick();
            end
        end
        cl_ready = 1'b0;
        checks++;
        if (!done_seen || hs != 8) begin
            errors++;
            $display("FAIL ones_count: round_done_seen=%b handshakes=%0d, required 1 8",
                     done_seen, hs);
        end
        tick();
    endtask

    task automatic test_reset_mid_round();
        cl_ready = 1'b0; flag_valid = 1'b1; flag_vec = 8'h08;
        tick();
        flag_vec = 8'h30;
        tick();
        flag_valid = 1'b0; flag_vec = 8'h00;
        checks++;
        if (pending !== 8'h30 || cl_valid !== 1'b1 || cl_idx !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: pending=%h valid=%b idx=%0d busy=%b, required 30 1 3 1",
                     pending, cl_valid, cl_idx, busy);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pending !== 8'h00 || cl_valid !== 1'b0 || cl_idx !== 3'd0 || busy !== 1'b0 ||
            round_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: pending=%h valid=%b idx=%0d busy=%b rd=%b, required 00 0 0 0 0",
                     pending, cl_valid, cl_idx, busy, round_done);
        end
        @(negedge clk);
        rst = 1'b0;
        cl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (cl_valid !== 1'b0 || pending !== 8'h00 || busy !== 1'b0 || round_done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet%0d: valid=%b pending=%h busy=%b rd=%b, required 0 00 0 0",
                         k, cl_valid, pending, busy, round_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_backpressure();
        test_reflag_same_cycle();
        test_flush();
        test_all_ones_backpressure();
        test_reset_mid_round();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcp_clause_scheduler.md
Name: bcp_clause_scheduler

Overview:
- Sits directly upstream of the clause priority encoder in the BCP unit.
- Accumulates clause-pending flags raised by the literal-evaluation logic into a pending vector.
- Issues one pending clause index per cycle, lowest index first, over a valid/ready handshake to the clause-evaluation stage, clearing each bit as it is issued.
- Signals the end of a propagation round so the control FSM can decide, branch or backtrack.

Parameters:
CLAUSE_NUM, 8, number of clauses tracked (`clause_num); must be >= 2.
CLAUSE_NUM_LOG, 3, index width (`clause_num_log); equals ceil(log2(CLAUSE_NUM)).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
flag_valid  input  1  flag_vec is valid this cycle.
flag_vec  input  CLAUSE_NUM  clauses to mark pending (bit i = clause i).
flush  input  1  discard all pending work (conflict/backtrack).
cl_valid  output  1  cl_idx holds a clause to evaluate.
cl_idx  output  CLAUSE_NUM_LOG  issued clause index.
cl_ready  input  1  downstream accepts cl_idx this cycle.
pending  output  CLAUSE_NUM  current pending vector (debug/observability).
busy  output  1  FSM in BUSY.
round_done  output  1  one-cycle pulse when a round completes.

Behaviour:
- Reset (async, rst=1) values: pending=0, cl_valid=0, cl_idx=0, busy=0, round_done=0, FSM=IDLE.
- Output slot: cl_valid/cl_idx form a single registered slot.
  - The slot loads when it is empty, or when it is full and cl_ready=1 (pop).
  - Load value: the lowest set bit of the pending register, computed by a priority-encode equivalent to the downstream encoder (lowest index wins).
  - If pending=0 at a load opportunity, cl_valid goes 0 (on pop) or stays 0.
- Pending update each cycle, in this order:
  - next = pending.
  - Clear the bit being loaded into the slot.
  - OR in flag_vec if flag_valid=1. A set beats a same-cycle clear of the same bit: a re-flagged clause is reissued later.
- Latency and throughput:
  - flag_vec at edge t -> pending at t+1 -> cl_valid at t+2 (empty slot).
  - With cl_ready held 1, one index is issued per cycle with no bubbles.
- Handshake:
  - cl_idx is stable while cl_valid=1 and cl_ready=0.
  - cl_valid never drops without a pop or flush.
  - An issued index is never left in pending.
- flush=1 (synchronous):
  - Next cycle: pending=0 and cl_valid=0.
  - flag_vec presented in the same cycle is dropped (flush wins).
  - FSM -> IDLE with no round_done pulse.
- FSM:
  - IDLE -> BUSY when the pending register is nonzero or cl_valid=1.
  - BUSY -> IDLE when pending=0, cl_valid=0 and flag_valid=0 in that cycle; round_done=1 for exactly one cycle on that transition.
  - busy=1 iff state=BUSY.
- Boundaries:
  - An all-ones flag_vec issues indices 0..CLAUSE_NUM-1 in order.
  - Bit CLAUSE_NUM-1 must encode correctly; no off-by-one past the top index.
  - Index widths never wrap.
  - An asynchronous reset mid-round aborts immediately with no round_done pulse.
- No combinational path from cl_ready to cl_valid or cl_idx.

Test Plan:
- Reset then flag_vec=8'b1010_0100 (one cycle), cl_ready=1 -> cl_idx 2,5,7 on consecutive cycles from t+2; pending reaches 0; round_done pulses one cycle after 7 is popped.
- cl_ready=0 for 4 cycles with flag_vec=8'b0001_1000 -> cl_valid=1 and cl_idx=3 held stable; pending=8'b0001_0000; after cl_ready=1, issue 4.
- Flag bit 3 in the same cycle slot loads index 3 -> index 3 issued twice, no loss.
- Flush while pending=8'hF0 and cl_valid=1, flag_vec=8'h01 same cycle -> next cycle pending=0, cl_valid=0, no round_done, busy=0.
- flag_vec=8'hFF, random cl_ready backpressure -> exactly 8 handshakes, indices 0..7 ascending, then round_done.
- Assert rst mid-round (pending=8'h30) -> outputs return to reset values immediately; no issue after rst deasserts.
